// File: rtl/fetch_pc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc
// Description : Program counter and instruction-fetch stage. Issues req/ack
//               fetches, buffers one word when decode stalls, and redirects
//               on taken jumps with a one-cycle flush pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc #(
    parameter int              PC_W      = 16,
    parameter int              INSTR_W   = 16,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               jmp_true,
    input  logic [PC_W-1:0]    jmp_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic               flush
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [PC_W-1:0]    r_pending_pc;
    logic [PC_W-1:0]    w_pending_pc_nxt;
    logic [INSTR_W-1:0] r_skid;
    logic [INSTR_W-1:0] w_skid_nxt;
    logic [PC_W-1:0]    r_skid_pc;
    logic [PC_W-1:0]    w_skid_pc_nxt;
    logic               w_valid_nxt;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic [PC_W-1:0]    w_if_pc_nxt;
    logic               w_flush_nxt;
    logic [PC_W-1:0]    w_pc_inc;

    assign w_pc_inc = r_pc + PC_W'(1);

    // The PC is left on the abandoned address during DRAIN, so the request
    // address is always the PC.
    assign imem_req  = (r_state == ST_REQ) || (r_state == ST_DRAIN);
    assign imem_addr = r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_VEC;
            r_pending_pc <= '0;
            r_skid       <= '0;
            r_skid_pc    <= '0;
            if_valid     <= 1'b0;
            if_instr     <= '0;
            if_pc        <= '0;
            flush        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pending_pc <= w_pending_pc_nxt;
            r_skid       <= w_skid_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
            if_valid     <= w_valid_nxt;
            if_instr     <= w_instr_nxt;
            if_pc        <= w_if_pc_nxt;
            flush        <= w_flush_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pending_pc_nxt = r_pending_pc;
        w_skid_nxt       = r_skid;
        w_skid_pc_nxt    = r_skid_pc;
        w_valid_nxt      = if_valid;
        w_instr_nxt      = if_instr;
        w_if_pc_nxt      = if_pc;
        w_flush_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
                if (jmp_true) begin
                    w_pc_nxt    = jmp_target;
                    w_flush_nxt = 1'b1;
                end
            end
            ST_REQ: begin
                if (jmp_true) begin
                    w_valid_nxt = 1'b0;
                    w_flush_nxt = 1'b1;
                    if (imem_ack) begin
                        w_pc_nxt = jmp_target;
                    end else begin
                        w_pending_pc_nxt = jmp_target;
                        w_state_nxt      = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    if (!stall) begin
                        w_instr_nxt = imem_rdata;
                        w_if_pc_nxt = r_pc;
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                    end else begin
                        w_skid_nxt    = imem_rdata;
                        w_skid_pc_nxt = r_pc;
                        w_state_nxt   = ST_HOLD;
                    end
                end else if (!stall) begin
                    w_valid_nxt = 1'b0;
                end
            end
            ST_HOLD: begin
                if (jmp_true) begin
                    w_pc_nxt    = jmp_target;
                    w_valid_nxt = 1'b0;
                    w_flush_nxt = 1'b1;
                    w_state_nxt = ST_REQ;
                end else if (!stall) begin
                    w_instr_nxt = r_skid;
                    w_if_pc_nxt = r_skid_pc;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // The abandoned word is dropped; a newer jump replaces the target.
                if (jmp_true) begin
                    w_pending_pc_nxt = jmp_target;
                    w_flush_nxt      = 1'b1;
                end
                if (imem_ack) begin
                    w_pc_nxt    = jmp_true ? jmp_target : r_pending_pc;
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/fetch_pc.md
Name: fetch_pc

Overview:
- Program-counter and instruction-fetch stage for the core.
- Holds the PC and issues req/ack fetches to instruction memory.
- Presents fetched instructions to decode, one per handshake.
- Consumes the branch unit's jmp_true and target. On a taken jump it redirects the PC, discards any wrong-path fetch and pulses a flush to the downstream stages.

Parameters:
PC_W, 16, PC and address width; the PC counts 16-bit instruction words.
INSTR_W, 16, instruction width.
RESET_VEC, 0, PC value loaded on reset.

Ports:
clk  in  1  core clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  downstream cannot accept a new instruction; if_* outputs must hold.
jmp_true  in  1  taken-jump indication from the branch unit.
jmp_target  in  PC_W  jump destination; sampled when jmp_true=1.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  PC_W  fetch address; stable while imem_req=1.
imem_ack  in  1  memory has returned data this cycle; completes the request.
imem_rdata  in  INSTR_W  fetched word; valid when imem_ack=1.
if_valid  out  1  if_instr/if_pc hold a valid instruction.
if_instr  out  INSTR_W  registered instruction to decode.
if_pc  out  PC_W  address of if_instr.
flush  out  1  one-cycle registered pulse per redirect; kills younger stages.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - pc=RESET_VEC, state=IDLE.
  - imem_req=0, if_valid=0, if_instr=0, if_pc=0, flush=0.
  - skid buffer and pending_pc cleared.
- Reset asserted mid-operation aborts everything immediately. Any outstanding request is abandoned, and memory must tolerate imem_req dropping.
- States: IDLE, REQ, HOLD, DRAIN. imem_req=1 only in REQ and DRAIN. imem_addr = pc in REQ, and the latched old address in DRAIN.
- flush defaults to 0 every cycle. It is set for exactly one cycle after each cycle in which jmp_true=1 is accepted.
- Priority within a cycle: jmp_true > imem_ack > stall.
- IDLE: after reset release, one cycle, then -> REQ. jmp_true in IDLE: pc<=jmp_target, flush, -> REQ.
- REQ:
  - jmp_true & imem_ack: drop the data; pc<=jmp_target; if_valid<=0; flush<=1; stay in REQ.
  - jmp_true & !imem_ack: pending_pc<=jmp_target; if_valid<=0; flush<=1; -> DRAIN. The address stays on the old pc.
  - imem_ack & !stall: if_instr<=imem_rdata; if_pc<=pc; if_valid<=1; pc<=pc+1; stay in REQ. This gives one instruction per cycle with a zero-wait memory.
  - imem_ack & stall: skid<=imem_rdata, skid_pc<=pc; if_* hold; -> HOLD.
  - !imem_ack & !stall: if_valid<=0.
  - !imem_ack & stall: if_* hold.
- HOLD:
  - imem_req=0; if_* hold.
  - !stall: if_* <= skid, if_valid<=1; pc<=pc+1; -> REQ.
  - jmp_true: skid discarded; pc<=jmp_target; if_valid<=0; flush; -> REQ.
- DRAIN: waits for the abandoned request to complete.
  - imem_ack: data discarded; pc<=pending_pc; -> REQ.
  - jmp_true in DRAIN: pending_pc<=new target, flush pulses again. If it coincides with imem_ack, pc<=new target.
  - if_valid stays 0.
- A redirect overrides stall: if_valid clears even while stall=1.
- Arithmetic: pc+1 is modulo 2^PC_W, so 0xFFFF wraps to 0x0000 with no flag. jmp_target is used unmodified.
- An instruction is never delivered twice or skipped. Each ack is consumed by exactly one of: deliver, skid, or discard.

Test Plan:
- Reset, release, imem_ack tied to imem_req, rdata=addr^0xA5A5 -> req first high at cycle 2 with addr 0x0000. if_pc runs 0,1,2,... with if_valid=1 back-to-back.
- Same as above, but stall=1 for 3 cycles starting as addr 0x0004 is acked -> if_pc stays 0x0003 through the stall. Then 0x0004 appears from the skid buffer, and the next request uses 0x0005. No loss, no duplicate.
- jmp_true=1, jmp_target=0x0100 while the ack for 0x0007 is delayed 2 cycles -> flush is one cycle. imem_addr stays 0x0007 until ack, that data is dropped, the next request is 0x0100, and if_valid=0 until the 0x0100 word arrives.
- jmp_true during HOLD with target 0x0040 -> the skid word is never delivered, flush pulses, the next if_pc is 0x0040.
- jmp_target=0xFFFE, then free run -> if_pc sequence is 0xFFFE, 0xFFFF, 0x0000.
- rst asserted asynchronously mid-DRAIN -> all outputs reach their reset values without a clock edge. After release, fetch restarts at RESET_VEC.
